// File: rtl/uart_word_tx.sv
// Purpose : 32-bit word UART transmitter (8N1, LSB byte first) fed by a small word FIFO.
// Latency : a word written at edge E drives the start bit at edge E+1; 40*BPS_CNT cycles per word.
// Backpr. : Full is registered and stays high while DEPTH words are queued; writes made while Full is high are dropped.
// Ports   : clk, reset (sync, active-high) | WrEn/WrData write side, Full | Busy status, tx serial line (idle high).
module uart_word_tx #(
    parameter int BPS_CNT = 868,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WrEn,
    input  logic [31:0] WrData,
    output logic        Full,
    output logic        Busy,
    output logic        tx
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [9:0]    BAUD_LAST = 10'(BPS_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Word FIFO
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          push;
    logic          pop;

    // Serializer
    state_t        state_q;
    state_t        state_d;
    logic [9:0]    baud_q;
    logic [9:0]    baud_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [1:0]    byte_q;
    logic [1:0]    byte_d;
    logic [31:0]   shift_q;
    logic [31:0]   shift_d;
    logic          tx_q;
    logic          tx_d;
    logic          baud_last;

    // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign push      = WrEn & ~full_q;
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= WrData;
        end
    end

    // The shift register moves right once per data bit, so after 8 bits
    // the next byte sits in shift_q[7:0] and the current bit is always shift_q[0].
    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? 10'd0 : baud_q + 10'd1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                // Only a word already registered in the FIFO may start a frame.
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    byte_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (byte_q != 2'd3) begin
                        // Next byte starts immediately, no idle gap inside a word.
                        byte_d  = byte_q + 2'd1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign Full = full_q;
    assign Busy = (state_q != IDLE) | (count_q != '0);
    assign tx   = tx_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Purpose : self-checking bench for uart_word_tx at BPS_CNT=4, DEPTH=4 with a UART receiver model.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : exercises Full by back-to-back writes while a word is in flight.
module tb_uart_word_tx;
    logic        clk;
    logic        reset;
    logic        WrEn;
    logic [31:0] WrData;
    logic        Full;
    logic        Busy;
    logic        tx;

    int n_cmp = 0;
    int n_err = 0;

    uart_word_tx #(.BPS_CNT(4), .DEPTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .WrEn   (WrEn),
        .WrData (WrData),
        .Full   (Full),
        .Busy   (Busy),
        .tx     (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // UART receiver model: samples mid-bit at 4 cycles per bit.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_sh = '0;
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    int         rx_ferr = 0;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 2) begin
                if (tx !== 1'b0) rx_ferr++;
            end else if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 2) % 4) == 0) begin
                rx_sh = {tx, rx_sh[7:1]};
            end else if (rx_cnt == 38) begin
                if (tx !== 1'b1) rx_ferr++;
                rx_q.push_back(rx_sh);
                rx_act = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic check_rx(input string name);
        check({name, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (Busy && n < bound) begin
            step();
            n++;
        end
        check({name, "_idle"}, {31'd0, Busy}, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] dat;
        logic        full;
        logic        busy;
        logic        txv;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int highs;
        int lows;

        // Back-to-back writes from empty: W0 pops on the 2nd edge, Full after the 5th accept,
        // W5 dropped. tx shows the start bit until START ends on the 6th edge (bit0 of 0x11 = 1).
        vecs[0] = '{1'b1, 32'h44332211, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 32'hA5C30F81, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 32'h01234567, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h89ABCDEF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'h55AA33CC, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

        // Reset, with a write presented while reset is held
        reset  = 1'b1;
        WrEn   = 1'b0;
        WrData = '0;
        step();
        step();
        WrEn   = 1'b1;
        WrData = 32'hBAD0BAD0;
        step();
        WrEn = 1'b0;
        check("rst_tx",   {31'd0, tx},   32'd1);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_full", {31'd0, Full}, 32'd0);
        reset = 1'b0;
        step();
        check("rst_write_ignored", {31'd0, Busy}, 32'd0);
        step();
        check("idle_tx", {31'd0, tx}, 32'd1);

        // Single word: no bypass, start at E+1, Busy falls 160 cycles after E+1
        WrEn   = 1'b1;
        WrData = 32'h44332211;
        step();
        WrEn = 1'b0;
        check("no_bypass_tx",  {31'd0, tx},   32'd1);
        check("busy_after_wr", {31'd0, Busy}, 32'd1);
        step();
        check("start_low", {31'd0, tx}, 32'd0);
        for (int k = 1; k <= 160; k++) begin
            step();
            if (k == 159) check("busy_k159", {31'd0, Busy}, 32'd1);
            if (k == 160) check("busy_k160", {31'd0, Busy}, 32'd0);
        end
        push_word(32'h44332211);
        check_rx("single");
        step();
        step();

        // Table: fill the FIFO while the first word transmits
        for (int i = 0; i < 7; i++) begin
            WrEn   = vecs[i].wr;
            WrData = vecs[i].dat;
            step();
            WrEn = 1'b0;
            check($sformatf("vec%0d_full", i), {31'd0, Full}, {31'd0, vecs[i].full});
            check($sformatf("vec%0d_busy", i), {31'd0, Busy}, {31'd0, vecs[i].busy});
            check($sformatf("vec%0d_tx", i),   {31'd0, tx},   {31'd0, vecs[i].txv});
        end
        wait_idle("fill", 3000);
        for (int i = 0; i < 5; i++) push_word(vecs[i].dat);
        check_rx("fill");
        step();
        step();

        // Two queued words: inter-word gap, then a write on the same edge as the IDLE pop
        WrEn   = 1'b1;
        WrData = 32'h44332211;
        step();
        WrData = 32'h8899AABB;
        step();
        WrEn = 1'b0;
        check("gap_first_start", {31'd0, tx}, 32'd0);
        highs = 0;
        for (int k = 1; k <= 160; k++) begin
            step();
            if (k == 155) check("gap_last_data_bit", {31'd0, tx}, 32'd0);
            if (k >= 156 && tx === 1'b1) highs++;
            if (k == 160) begin
                WrEn   = 1'b1;
                WrData = 32'h0F1E2D3C;
            end
        end
        step();
        WrEn = 1'b0;
        check("gap_second_start", {31'd0, tx}, 32'd0);
        check("gap_high_cycles", highs, 32'd5);
        check("pop_wr_full", {31'd0, Full}, 32'd0);
        for (int k = 162; k <= 482; k++) begin
            step();
            if (k == 481) check("pop_wr_busy_k481", {31'd0, Busy}, 32'd1);
            if (k == 482) check("pop_wr_busy_k482", {31'd0, Busy}, 32'd0);
        end
        push_word(32'h44332211);
        push_word(32'h8899AABB);
        push_word(32'h0F1E2D3C);
        check_rx("gap");
        step();
        step();

        // All-zero then all-one word framing
        WrEn   = 1'b1;
        WrData = 32'h00000000;
        step();
        WrData = 32'hFFFFFFFF;
        step();
        WrEn = 1'b0;
        wait_idle("zero_ones", 1000);
        push_word(32'h00000000);
        push_word(32'hFFFFFFFF);
        check_rx("zero_ones");
        step();
        step();

        // Reset during DATA of byte 2 with a full FIFO queued behind it
        for (int i = 0; i < 5; i++) begin
            WrEn   = 1'b1;
            WrData = 32'h11111111 * (i + 1);
            step();
        end
        WrEn = 1'b0;
        // Frame started at the 2nd write edge, so now k=3 relative to the start edge.
        for (int k = 4; k <= 89; k++) step();
        check("full_before_rst", {31'd0, Full}, 32'd1);
        reset  = 1'b1;
        WrEn   = 1'b1;
        WrData = 32'hCAFEF00D;
        step();
        check("abort_tx",   {31'd0, tx},   32'd1);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_full", {31'd0, Full}, 32'd0);
        reset = 1'b0;
        WrEn  = 1'b0;
        lows  = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (tx !== 1'b1) lows++;
        end
        check("abort_no_start", lows, 32'd0);
        check("abort_busy_after", {31'd0, Busy}, 32'd0);
        rx_q.delete();
        exp_q.delete();

        check("framing_errors", rx_ferr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
